// File: rtl/disp_pkg.sv
// Shared display definitions: duty width, brightness op codes, sequencer states.
// Also hosts the one-step fade helper used by the brightness sequencer.
package disp_pkg;

  localparam int DUTY_W = 6;

  typedef enum logic [1:0] {
    OP_SET   = 2'b00,
    OP_FADE  = 2'b01,
    OP_BLINK = 2'b10,
    OP_OFF   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FADE  = 2'b01,
    ST_BLINK = 2'b10
  } state_e;

  // Caller guarantees cur != tgt, so the result never wraps.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    return (cur < tgt) ? cur + 1'b1 : cur - 1'b1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, synchronous clear restarts the count.
// Tick is high while the count sits at DIV-1.
module tick_gen #(
  parameter int DIV = 50000
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_bright_seq.sv
// Brightness sequencer for the display PWM: set / linear fade / blink / off over valid-ready.
// Duty and enable change only on prescaled ticks (or one cycle after an accepted command).
module pwm_bright_seq
  import disp_pkg::*;
#(
  parameter int TICK_DIV        = 50000,
  parameter int FADE_STEP_TICKS = 4,
  parameter int BLINK_TICKS     = 500
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_level,
  output logic [5:0]  duty,
  output logic        en,
  output logic        busy,
  output logic        fade_done
);

  localparam int SW = (FADE_STEP_TICKS > 1) ? $clog2(FADE_STEP_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  state_e              state_q, state_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic [DUTY_W-1:0]   target_q, target_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                phase_q, phase_d;
  logic [SW-1:0]       step_q, step_d;
  logic [BW-1:0]       blink_q, blink_d;
  logic [DUTY_W-1:0]   next_duty;
  logic                accept;
  logic                tick;

  assign cmd_ready = (state_q != ST_FADE);
  assign accept    = cmd_valid && cmd_ready;

  // An accepted command restarts the prescaler, so a coincident tick is dropped.
  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .clr      (accept),
    .tick     (tick)
  );

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    target_d  = target_q;
    en_d      = en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    phase_d   = phase_q;
    step_d    = step_q;
    blink_d   = blink_q;
    next_duty = step_toward(duty_q, target_q);

    if (accept) begin
      step_d  = '0;
      blink_d = '0;
      busy_d  = 1'b0;
      state_d = ST_IDLE;
      case (op_e'(cmd_op))
        OP_SET: begin
          duty_d = cmd_level;
          en_d   = (cmd_level != '0);
        end
        OP_FADE: begin
          target_d = cmd_level;
          if (cmd_level == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_FADE;
            busy_d  = 1'b1;
          end
        end
        OP_BLINK: begin
          duty_d  = cmd_level;
          en_d    = (cmd_level != '0);
          phase_d = 1'b1;
          state_d = ST_BLINK;
        end
        default: en_d = 1'b0;
      endcase
    end else if (tick) begin
      case (state_q)
        ST_FADE: begin
          if (step_q == SW'(FADE_STEP_TICKS - 1)) begin
            step_d = '0;
            duty_d = next_duty;
            en_d   = (next_duty != '0);
            if (next_duty == target_q) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        ST_BLINK: begin
          if (blink_q == BW'(BLINK_TICKS - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
            en_d    = ~phase_q && (duty_q != '0);
          end else begin
            blink_d = blink_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      duty_q   <= '0;
      target_q <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      phase_q  <= 1'b0;
      step_q   <= '0;
      blink_q  <= '0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      phase_q  <= phase_d;
      step_q   <= step_d;
      blink_q  <= blink_d;
    end
  end

  assign duty      = duty_q;
  assign en        = en_q;
  assign busy      = busy_q;
  assign fade_done = done_q;

endmodule

// File: tb/tb_pwm_bright_seq.sv
// Bench for pwm_bright_seq: elapsed-time reference model compared every cycle,
// directed scenarios with literal expectations, then randomized commands and resets.
module tb_pwm_bright_seq;
  import disp_pkg::*;

  localparam int TD = 4;
  localparam int FS = 2;
  localparam int BT = 3;
  localparam longint FP = TD * FS;   // clocks per fade step
  localparam longint BP = TD * BT;   // clocks per blink half-period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [5:0] cmd_level = 6'd0;
  logic [5:0] duty;
  logic       en, busy, fade_done;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pwm_bright_seq #(.TICK_DIV(TD), .FADE_STEP_TICKS(FS), .BLINK_TICKS(BT)) dut (
    .CLOCK_50  (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_level (cmd_level),
    .duty      (duty),
    .en        (en),
    .busy      (busy),
    .fade_done (fade_done)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: mode 0 idle, 1 fading, 2 blinking; steps derived from
  // clocks elapsed since the accepting edge.
  int     m_mode = 0, m_duty = 0, m_tgt = 0, m_en = 0, m_done = 0;
  longint edge_cnt = 0, m_acc = 0, el;

  always @(posedge clk) begin
    edge_cnt++;
    m_done = 0;
    if (!rst_n) begin
      m_mode = 0; m_duty = 0; m_en = 0; m_tgt = 0;
    end else if (cmd_valid && m_mode != 1) begin
      m_acc  = edge_cnt;
      m_mode = 0;
      case (cmd_op)
        2'b00: begin m_duty = cmd_level; m_en = (cmd_level != 0); end
        2'b01: begin
          if (int'(cmd_level) == m_duty) m_done = 1;
          else begin m_mode = 1; m_tgt = cmd_level; end
        end
        2'b10: begin m_duty = cmd_level; m_en = (cmd_level != 0); m_mode = 2; end
        default: m_en = 0;
      endcase
    end else if (m_mode == 1) begin
      el = edge_cnt - m_acc;
      if (el % FP == 0) begin
        m_duty = (m_tgt > m_duty) ? m_duty + 1 : m_duty - 1;
        m_en   = (m_duty != 0);
        if (m_duty == m_tgt) begin m_done = 1; m_mode = 0; end
      end
    end else if (m_mode == 2) begin
      el = edge_cnt - m_acc;
      if (el % BP == 0) m_en = ((el / BP) % 2 == 0) && (m_duty != 0);
    end
  end

  always @(negedge clk) begin
    if (edge_cnt > 0)
      check("model{duty,en,busy,done,ready}",
            int'({duty, en, busy, fade_done, cmd_ready}),
            (m_duty << 4) | (m_en << 3) | ((m_mode == 1) << 2) | (m_done << 1) | (m_mode != 1));
  end

  task automatic send(input logic [1:0] op, input int lvl);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_level = 6'(lvl);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset held with a command pending
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = OP_SET; cmd_level = 6'd40;
    for (int i = 0; i < 3; i++) begin
      edges(1);
      check("rst_duty", duty, 0);
      check("rst_en", en, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
    end
    cmd_valid = 1'b0; rst_n = 1'b1;
    edges(1);
    check("post_rst_duty", duty, 0);

    // SET 40 then SET 0
    send(OP_SET, 40); #1;
    check("set40_duty", duty, 40);
    check("set40_en", en, 1);
    send(OP_SET, 0); #1;
    check("set0_duty", duty, 0);
    check("set0_en", en, 0);

    // FADE 0->3 with valid held high throughout
    cmd_valid = 1'b1; cmd_op = OP_FADE; cmd_level = 6'd3;
    @(posedge clk);
    #2 cmd_op = OP_SET; cmd_level = 6'd50;
    check("fade_busy_k", busy, 1);
    check("fade_ready_k", cmd_ready, 0);
    for (int i = 1; i <= 24; i++) begin
      edges(1);
      if (i == 7)  check("fade_duty_k7", duty, 0);
      if (i == 8)  check("fade_duty_k8", duty, 1);
      if (i == 16) check("fade_duty_k16", duty, 2);
      if (i == 23) check("fade_done_k23", fade_done, 0);
      if (i == 23) check("fade_busy_k23", busy, 1);
    end
    check("fade_duty_k24", duty, 3);
    check("fade_done_k24", fade_done, 1);
    check("fade_busy_k24", busy, 0);
    check("fade_ready_k24", cmd_ready, 1);
    cmd_valid = 1'b0;
    edges(1);
    check("fade_duty_k25", duty, 3);
    check("fade_done_k25", fade_done, 0);

    // FADE to the current level
    send(OP_SET, 20);
    send(OP_FADE, 20); #1;
    check("fade_eq_done", fade_done, 1);
    check("fade_eq_busy", busy, 0);
    check("fade_eq_duty", duty, 20);
    edges(1);
    check("fade_eq_done_off", fade_done, 0);

    // BLINK 10, then SET 5 mid-blink
    send(OP_BLINK, 10); #1;
    check("blink_en_k", en, 1);
    check("blink_duty_k", duty, 10);
    for (int i = 1; i <= 30; i++) begin
      edges(1);
      if (i == 11) check("blink_en_k11", en, 1);
      if (i == 12) check("blink_en_k12", en, 0);
      if (i == 23) check("blink_en_k23", en, 0);
      if (i == 24) check("blink_en_k24", en, 1);
    end
    send(OP_SET, 5); #1;
    check("blink_set_duty", duty, 5);
    check("blink_set_en", en, 1);
    edges(30);
    check("blink_stopped_en", en, 1);

    // OFF retains duty, FADE resumes from it
    send(OP_SET, 30);
    send(OP_OFF, 0); #1;
    check("off_en", en, 0);
    check("off_duty", duty, 30);
    send(OP_FADE, 28); #1;
    check("off_fade_en_k", en, 0);
    for (int i = 1; i <= 16; i++) begin
      edges(1);
      if (i == 8) check("off_fade_duty_k8", duty, 29);
      if (i == 8) check("off_fade_en_k8", en, 1);
    end
    check("off_fade_duty_k16", duty, 28);
    check("off_fade_done_k16", fade_done, 1);

    // Reset mid-fade
    send(OP_FADE, 0);
    edges(10);
    rst_n = 1'b0;
    edges(1);
    check("midrst_duty", duty, 0);
    check("midrst_en", en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", cmd_ready, 1);
    rst_n = 1'b1;

    // Randomized commands with occasional resets
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      rst_n     = ($urandom_range(0, 499) != 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_level = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63))
                                              : 6'($urandom_range(0, 4));
    end
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    edges(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
